// File: rtl/frame_commit_ctrl_pkg.sv
// Shared VGA timing constants and the commit FSM state encoding.
package frame_commit_ctrl_pkg;

  localparam int unsigned H_VIEW  = 32'd640;
  localparam int unsigned V_VIEW  = 32'd480;
  localparam int unsigned V_TOTAL = 32'd525;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EVAL  = 2'd1,
    ST_PULSE = 2'd2,
    ST_HOLD  = 2'd3
  } fsm_state_e;

endpackage

// File: rtl/frame_commit_ctrl.sv
// Schedules the register-block load_new strobe at one fixed vblank point per frame,
// with decimation, freeze, one-shot force and a sticky missed-update flag.
module frame_commit_ctrl
  import frame_commit_ctrl_pkg::*;
#(
  parameter int unsigned       POS_W       = 10,
  parameter int unsigned       DIV_W       = 4,
  parameter int unsigned       FCOUNT_W    = 8,
  parameter logic [POS_W-1:0]  COMMIT_VPOS = POS_W'(V_VIEW),
  parameter logic [POS_W-1:0]  COMMIT_HPOS = {POS_W{1'b0}}
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [POS_W-1:0]    hpos,
  input  logic [POS_W-1:0]    vpos,
  input  logic                i_pending,
  input  logic                i_freeze,
  input  logic [DIV_W-1:0]    i_div,
  input  logic                i_force,
  input  logic                i_clr_missed,
  output logic                o_load_new,
  output logic [FCOUNT_W-1:0] o_frame_count,
  output logic                o_missed,
  output logic                o_force_pend
);

  fsm_state_e          state_q, state_d;
  logic                match_s;
  logic                match_q, match_dly_q;
  logic                event_s;
  logic                eligible_s;
  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic [FCOUNT_W-1:0] fcount_q, fcount_d;
  logic                load_new_q, load_new_d;
  logic                missed_q, missed_d;
  logic                force_pend_q, force_pend_d;
  logic                missed_set_s;
  logic                force_clr_s;

  assign match_s    = (hpos == COMMIT_HPOS) && (vpos == COMMIT_VPOS);
  // A beam stalled on the match point yields a single event: only the rising edge counts.
  assign event_s    = match_q && !match_dly_q;
  assign eligible_s = (div_cnt_q == {DIV_W{1'b0}}) || force_pend_q;

  // Force set wins over a same-cycle clear so a late request is serviced next frame.
  assign force_pend_d = i_force || (force_pend_q && !force_clr_s);
  assign missed_d     = missed_set_s || (missed_q && !i_clr_missed);

  // Next-state, divider, frame counter and strobe decode.
  always_comb begin
    state_d      = state_q;
    div_cnt_d    = div_cnt_q;
    fcount_d     = fcount_q;
    load_new_d   = 1'b0;
    missed_set_s = 1'b0;
    force_clr_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (event_s) begin
          state_d  = ST_EVAL;
          fcount_d = fcount_q + FCOUNT_W'(1);
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_EVAL: begin
        if (eligible_s && !i_freeze) begin
          state_d     = ST_PULSE;
          div_cnt_d   = i_div;
          force_clr_s = 1'b1;
          load_new_d  = 1'b1;
        end else if (!eligible_s) begin
          state_d   = ST_HOLD;
          div_cnt_d = div_cnt_q - DIV_W'(1);
        end else begin
          state_d      = ST_HOLD;
          missed_set_s = i_pending;
        end
      end
      ST_PULSE: begin
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (!match_q) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      match_q      <= 1'b0;
      match_dly_q  <= 1'b0;
      div_cnt_q    <= {DIV_W{1'b0}};
      fcount_q     <= {FCOUNT_W{1'b0}};
      load_new_q   <= 1'b0;
      missed_q     <= 1'b0;
      force_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      match_q      <= match_s;
      match_dly_q  <= match_q;
      div_cnt_q    <= div_cnt_d;
      fcount_q     <= fcount_d;
      load_new_q   <= load_new_d;
      missed_q     <= missed_d;
      force_pend_q <= force_pend_d;
    end
  end

  assign o_load_new    = load_new_q;
  assign o_frame_count = fcount_q;
  assign o_missed      = missed_q;
  assign o_force_pend  = force_pend_q;

endmodule

// File: tb/tb_frame_commit_ctrl.sv
// Scoreboard bench for frame_commit_ctrl: a frame-level model queues the cycle of each
// expected commit strobe; a negedge monitor checks o_load_new against it every cycle.
module tb_frame_commit_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [9:0] hpos, vpos;
  logic       i_pending, i_freeze, i_force, i_clr_missed;
  logic [3:0] i_div;
  logic       o_load_new, o_missed, o_force_pend;
  logic [7:0] o_frame_count;

  frame_commit_ctrl dut (
    .clk(clk), .reset_n(reset_n), .hpos(hpos), .vpos(vpos),
    .i_pending(i_pending), .i_freeze(i_freeze), .i_div(i_div),
    .i_force(i_force), .i_clr_missed(i_clr_missed),
    .o_load_new(o_load_new), .o_frame_count(o_frame_count),
    .o_missed(o_missed), .o_force_pend(o_force_pend)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0d exp=%0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Reference model state
  int         sb_q[$];
  logic [7:0] fc_m;
  logic [3:0] div_m;
  logic       force_m, missed_m;
  bit         mon_en = 1'b0;

  task automatic model_reset();
    fc_m = 8'd0; div_m = 4'd0; force_m = 1'b0; missed_m = 1'b0;
    sb_q.delete();
  endtask

  // n = first cycle with the beam on the commit point
  task automatic model_event(input int n);
    bit elig;
    fc_m = fc_m + 8'd1;
    elig = (div_m == 4'd0) || force_m;
    if (elig && !i_freeze) begin
      sb_q.push_back(n + 3);
      div_m   = i_div;
      force_m = 1'b0;
    end else if (!elig) begin
      div_m = div_m - 4'd1;
    end else if (i_pending) begin
      missed_m = 1'b1;
    end
  endtask

  always @(negedge clk) begin
    bit exp_pulse;
    if (mon_en) begin
      exp_pulse = (sb_q.size() != 0) && (sb_q[0] == cyc);
      check_eq("load_new", {31'd0, o_load_new}, {31'd0, exp_pulse});
      if (exp_pulse) void'(sb_q.pop_front());
    end
  end

  task automatic check_status(input string tag);
    check_eq({tag, ".frame_count"}, {24'd0, o_frame_count}, {24'd0, fc_m});
    check_eq({tag, ".missed"}, {31'd0, o_missed}, {31'd0, missed_m});
    check_eq({tag, ".force_pend"}, {31'd0, o_force_pend}, {31'd0, force_m});
  endtask

  // One 16-cycle frame: commit point held for `stall` cycles starting at t=4.
  task automatic run_frame(input int stall, input int force_at, input string tag);
    for (int t = 0; t < 16; t++) begin
      @(posedge clk); #1;
      if (t >= 4 && t < 4 + stall) begin
        hpos = 10'd0; vpos = 10'd480;
      end else begin
        hpos = 10'd7; vpos = 10'd100;
      end
      if (t == 4) model_event(cyc);
      i_force = (t == force_at);
      if (t == force_at) force_m = 1'b1;
    end
    @(posedge clk); #1;
    i_force = 1'b0;
    check_status(tag);
  endtask

  task automatic pulse_force();
    @(posedge clk); #1; i_force = 1'b1; force_m = 1'b1;
    @(posedge clk); #1; i_force = 1'b0;
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1; i_clr_missed = 1'b1; missed_m = 1'b0;
    @(posedge clk); #1; i_clr_missed = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; hpos = 10'd7; vpos = 10'd100;
    i_pending = 1'b0; i_freeze = 1'b0; i_force = 1'b0; i_clr_missed = 1'b0; i_div = 4'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst.load_new", {31'd0, o_load_new}, 32'd0);
    check_status("rst");
    reset_n = 1'b1;
    mon_en  = 1'b1;

    // Every frame commits with div 0
    for (int f = 0; f < 4; f++) run_frame(1, -1, "div0");

    // Decimation: commits on frames 1, 4, 7
    i_div = 4'd2;
    for (int f = 0; f < 7; f++) run_frame(1, -1, "div2");

    // Drain the divider, then freeze with a pending update
    i_div = 4'd0;
    for (int f = 0; f < 3; f++) run_frame(1, -1, "drain");
    i_freeze = 1'b1; i_pending = 1'b1;
    for (int f = 0; f < 2; f++) run_frame(1, -1, "freeze");
    pulse_clr();
    check_status("clr");
    i_freeze = 1'b0;
    run_frame(1, -1, "unfreeze");
    i_pending = 1'b0;

    // Force overrides the divider
    i_div = 4'd3;
    run_frame(1, -1, "div3");
    pulse_force();
    check_status("force_set");
    run_frame(1, -1, "force");
    i_freeze = 1'b1;
    pulse_force();
    run_frame(1, -1, "force_frozen");
    i_freeze = 1'b0;
    run_frame(1, -1, "force_unfrozen");

    // Force arriving in the EVAL cycle survives the clear
    pulse_force();
    run_frame(1, 6, "force_collide");
    run_frame(1, -1, "force_late");

    // Beam stalled on the commit point for 6 clocks
    i_div = 4'd0;
    pulse_force();
    run_frame(6, -1, "stall");

    // Frame counter wraps
    for (int f = 0; f < 256; f++) run_frame(1, -1, "wrap");

    // Asynchronous reset while in HOLD, with i_div=5 reloaded by this commit
    i_div = 4'd5;
    @(posedge clk); #1; hpos = 10'd0; vpos = 10'd480; model_event(cyc);
    repeat (5) @(posedge clk);
    #3;
    mon_en  = 1'b0;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_eq("arst.load_new", {31'd0, o_load_new}, 32'd0);
    check_status("arst");
    repeat (2) @(posedge clk);
    #1; hpos = 10'd7; vpos = 10'd100;
    @(posedge clk); #1;
    reset_n = 1'b1;
    mon_en  = 1'b1;
    run_frame(1, -1, "post_rst");

    repeat (4) @(posedge clk);
    check_eq("sb_empty", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
